// File: rtl/pix_pkg.sv
// Shared constants, FSM state and memory-request payload for the pixel buffer port-A controller.
package pix_pkg;

  localparam int unsigned AW     = 13;
  localparam int unsigned DW     = 8;
  localparam int unsigned DEPTH  = 6144;
  localparam int unsigned RD_LAT = 3;

  localparam logic [DW-1:0] CLEAR_VAL = DW'(0);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic          cea;
    logic          wrea;
    logic [AW-1:0] ada;
    logic [DW-1:0] dina;
  } mem_req_t;

  // Only 0..DEPTH-1 are backed by buffer storage.
  function automatic logic addr_in_range(input logic [AW-1:0] addr);
    return 32'(addr) < DEPTH;
  endfunction

endpackage

// File: rtl/pix_port_arb_if.sv
// Request/response and buffer A-port signal bundle for pix_port_arb.
interface pix_port_arb_if;
  import pix_pkg::*;

  logic          clear_start;
  logic          busy;
  logic          clear_done;

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;

  logic          rdata_valid;
  logic [DW-1:0] rdata;

  logic          mem_cea;
  logic          mem_wrea;
  logic [AW-1:0] mem_ada;
  logic [DW-1:0] mem_dina;
  logic          mem_ocea;
  logic          mem_reseta;
  logic [DW-1:0] mem_douta;

  modport slave (
    input  clear_start, wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_douta,
    output busy, clear_done, wr_ready, rd_ready, rdata_valid, rdata,
           mem_cea, mem_wrea, mem_ada, mem_dina, mem_ocea, mem_reseta
  );

  modport master (
    output clear_start, wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_douta,
    input  busy, clear_done, wr_ready, rd_ready, rdata_valid, rdata,
           mem_cea, mem_wrea, mem_ada, mem_dina, mem_ocea, mem_reseta
  );

endinterface

// File: rtl/pix_rr_arb.sv
// Two-requester arbiter (bit 0 = write, bit 1 = read); PIX_ARB_RR_EN selects
// round-robin on contention, otherwise write has fixed priority.
module pix_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_c_o
);

`ifdef PIX_ARB_RR_EN
  logic last_rd_q, last_rd_d;

  // On contention grant the side that did not win last; any grant updates history.
  always_comb begin
    gnt_c_o   = req_i;
    last_rd_d = last_rd_q;
    if (req_i == 2'b11) begin
      gnt_c_o = last_rd_q ? 2'b01 : 2'b10;
    end
    if (gnt_c_o[0]) begin
      last_rd_d = 1'b0;
    end else if (gnt_c_o[1]) begin
      last_rd_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_rd_q <= 1'b1;
    end else begin
      last_rd_q <= last_rd_d;
    end
  end
`else
  logic unused_clk_rst;

  assign gnt_c_o        = req_i[0] ? 2'b01 : {req_i[1], 1'b0};
  assign unused_clk_rst = clk ^ reset;
`endif

endmodule

// File: rtl/pix_port_arb.sv
// Port-A controller for the 6144x8 pixel buffer: arbitrates writer, reader and
// frame-clear engine. Optional round-robin arbitration via PIX_ARB_RR_EN.
module pix_port_arb
  import pix_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  pix_port_arb_if.slave bus
);

  arb_state_e        state_q, state_d;
  logic [AW-1:0]     clr_addr_q, clr_addr_d;
  mem_req_t          mem_req_q, mem_req_d;
  logic              clear_done_q, clear_done_d;
  logic [RD_LAT-2:0] rd_vld_q, rd_vld_d;
  logic [RD_LAT-2:0] rd_inr_q, rd_inr_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              accept_c;
  logic [1:0]        arb_req, arb_gnt;

  // clear_start takes the port that cycle, so no handshake may complete with it.
  assign accept_c = (state_q == IDLE) && !bus.clear_start && !reset;
  assign arb_req  = accept_c ? {bus.rd_valid, bus.wr_valid} : 2'b00;

  pix_rr_arb u_arb (
    .clk    (clk),
    .reset  (reset),
    .req_i  (arb_req),
    .gnt_c_o(arb_gnt)
  );

  always_comb begin
    state_d       = state_q;
    clr_addr_d    = clr_addr_q;
    clear_done_d  = 1'b0;
    mem_req_d     = mem_req_q;
    mem_req_d.cea = 1'b0;
    mem_req_d.wrea = 1'b0;
    rd_vld_d      = rd_vld_q << 1;
    rd_inr_d      = rd_inr_q << 1;
    rdata_valid_d = rd_vld_q[RD_LAT-2];
    rdata_d       = rdata_q;
    // Out-of-range reads never touch the buffer and return zero.
    if (rd_vld_q[RD_LAT-2]) begin
      rdata_d = rd_inr_q[RD_LAT-2] ? bus.mem_douta : DW'(0);
    end

    case (state_q)
      IDLE: begin
        if (bus.clear_start) begin
          state_d        = CLEAR;
          clr_addr_d     = '0;
          mem_req_d.cea  = 1'b1;
          mem_req_d.wrea = 1'b1;
          mem_req_d.ada  = '0;
          mem_req_d.dina = CLEAR_VAL;
        end else if (arb_gnt[0]) begin
          if (addr_in_range(bus.wr_addr)) begin
            mem_req_d.cea  = 1'b1;
            mem_req_d.wrea = 1'b1;
            mem_req_d.ada  = bus.wr_addr;
            mem_req_d.dina = bus.wr_data;
          end
        end else if (arb_gnt[1]) begin
          rd_vld_d[0] = 1'b1;
          rd_inr_d[0] = addr_in_range(bus.rd_addr);
          if (addr_in_range(bus.rd_addr)) begin
            mem_req_d.cea = 1'b1;
            mem_req_d.ada = bus.rd_addr;
          end
        end
      end
      CLEAR: begin
        // Leave once the last address has been presented for a full cycle.
        if (clr_addr_q == AW'(DEPTH - 1)) begin
          state_d      = IDLE;
          clear_done_d = 1'b1;
        end else begin
          clr_addr_d     = clr_addr_q + AW'(1);
          mem_req_d.cea  = 1'b1;
          mem_req_d.wrea = 1'b1;
          mem_req_d.ada  = clr_addr_q + AW'(1);
          mem_req_d.dina = CLEAR_VAL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      clr_addr_q    <= '0;
      mem_req_q     <= '0;
      clear_done_q  <= 1'b0;
      rd_vld_q      <= '0;
      rd_inr_q      <= '0;
      rdata_valid_q <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      clr_addr_q    <= clr_addr_d;
      mem_req_q     <= mem_req_d;
      clear_done_q  <= clear_done_d;
      rd_vld_q      <= rd_vld_d;
      rd_inr_q      <= rd_inr_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_q       <= rdata_d;
    end
  end

  assign bus.wr_ready    = arb_gnt[0];
  assign bus.rd_ready    = arb_gnt[1];
  assign bus.busy        = (state_q == CLEAR);
  assign bus.clear_done  = clear_done_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.rdata       = rdata_q;
  assign bus.mem_cea     = mem_req_q.cea;
  assign bus.mem_wrea    = mem_req_q.wrea;
  assign bus.mem_ada     = mem_req_q.ada;
  assign bus.mem_dina    = mem_req_q.dina;
  assign bus.mem_ocea    = 1'b1;
  assign bus.mem_reseta  = reset;

endmodule

// File: tb/tb_pix_port_arb.sv
// Directed bench for pix_port_arb with a behavioural bypass-mode pixel buffer on port A.
module tb_pix_port_arb;
  import pix_pkg::*;

  localparam logic [34:0] RST_VEC = 35'h1;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic [DW-1:0] mem_model [DEPTH];

  pix_port_arb_if bus();

  pix_port_arb dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bypass read: data sampled at the edge is visible the following cycle.
  always @(posedge clk) begin
    if (bus.mem_cea === 1'b1 && int'(bus.mem_ada) < int'(DEPTH)) begin
      if (bus.mem_wrea) mem_model[bus.mem_ada] <= bus.mem_dina;
      else              bus.mem_douta <= mem_model[bus.mem_ada];
    end
  end

  function automatic logic [34:0] out_vec();
    return {bus.busy, bus.clear_done, bus.mem_cea, bus.mem_wrea, bus.rdata_valid,
            bus.mem_ada, bus.mem_dina, bus.rdata, bus.mem_ocea};
  endfunction

  task automatic read_word(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
    d   = 'x;
    lat = -1;
    @(negedge clk);
    bus.rd_valid = 1'b1;
    bus.rd_addr  = a;
    #1;
    if (bus.rd_ready !== 1'b1) begin
      bus.rd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.rd_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (bus.rdata_valid === 1'b1) begin
        lat = i;
        d   = bus.rdata;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d, output logic acc);
    @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    #1;
    acc = bus.wr_ready;
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.mem_reseta !== 1'b1) begin
      n_errors++; $display("FAIL reset_mem_reseta_hi: got %b want 1", bus.mem_reseta);
    end
    n_checks++;
    if (out_vec() !== RST_VEC) begin
      n_errors++; $display("FAIL reset_outputs: got %h want %h", out_vec(), RST_VEC);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.mem_reseta !== 1'b0) begin
      n_errors++; $display("FAIL reset_mem_reseta_lo: got %b want 0", bus.mem_reseta);
    end
    n_checks++;
    if (out_vec() !== RST_VEC) begin
      n_errors++; $display("FAIL idle_outputs: got %h want %h", out_vec(), RST_VEC);
    end
  endtask

  task automatic test_clear();
    int            busy_cnt = 0, done_cnt = 0, done_idx = -1, bad_wr = 0, rdy_seen = 0;
    int            lat;
    logic [DW-1:0] d;
    logic [AW-1:0] addrs [4];
    addrs[0] = 13'd0; addrs[1] = 13'd4095; addrs[2] = 13'd4096; addrs[3] = 13'd6143;
    @(negedge clk); bus.clear_start = 1'b1;
    @(negedge clk); bus.clear_start = 1'b0;
    for (int idx = 1; idx <= int'(DEPTH) + 16; idx++) begin
      if (bus.busy === 1'b1) begin
        busy_cnt++;
        if (bus.mem_cea !== 1'b1 || bus.mem_wrea !== 1'b1 ||
            int'(bus.mem_ada) != idx - 1 || bus.mem_dina !== 8'h00) bad_wr++;
      end
      if (bus.clear_done === 1'b1) begin
        done_cnt++;
        done_idx = idx;
      end
      if (bus.rd_ready === 1'b1) rdy_seen++;
      if (idx == 10) begin bus.rd_valid = 1'b1; bus.rd_addr = 13'd3; end
      if (idx == 20) bus.rd_valid = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (busy_cnt != int'(DEPTH)) begin
      n_errors++; $display("FAIL clear_busy_cycles: got %0d want %0d", busy_cnt, DEPTH);
    end
    n_checks++;
    if (done_cnt != 1 || done_idx != int'(DEPTH) + 1) begin
      n_errors++; $display("FAIL clear_done_pulse: got count %0d at %0d want 1 at %0d",
                           done_cnt, done_idx, DEPTH + 1);
    end
    n_checks++;
    if (bad_wr != 0) begin
      n_errors++; $display("FAIL clear_write_seq: got %0d bad cycles want 0", bad_wr);
    end
    n_checks++;
    if (rdy_seen != 0) begin
      n_errors++; $display("FAIL clear_rd_ready: got %0d ready cycles want 0", rdy_seen);
    end
    for (int k = 0; k < 4; k++) begin
      read_word(addrs[k], d, lat);
      n_checks++;
      if (lat != 3 || d !== 8'h00) begin
        n_errors++; $display("FAIL clear_readback[%0d]: got %h lat %0d want 00 lat 3", addrs[k], d, lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic acc, r0, r1;
    logic [15:0] got;
    write_word(13'd4095, 8'hA5, acc);
    n_checks++;
    if (acc !== 1'b1 || {bus.mem_cea, bus.mem_wrea, bus.mem_ada, bus.mem_dina} !== {2'b11, 13'd4095, 8'hA5}) begin
      n_errors++; $display("FAIL write_port: got acc %b cea %b wrea %b ada %0d dina %h want 1 1 1 4095 a5",
                           acc, bus.mem_cea, bus.mem_wrea, bus.mem_ada, bus.mem_dina);
    end
    @(negedge clk);
    n_checks++;
    if (bus.mem_cea !== 1'b0) begin
      n_errors++; $display("FAIL write_one_cycle: got cea %b want 0", bus.mem_cea);
    end
    write_word(13'd4096, 8'h3C, acc);
    @(negedge clk); bus.rd_valid = 1'b1; bus.rd_addr = 13'd4095; #1; r0 = bus.rd_ready;
    @(negedge clk); bus.rd_addr = 13'd4096; #1; r1 = bus.rd_ready;
    n_checks++;
    if (r0 !== 1'b1 || r1 !== 1'b1 || bus.mem_cea !== 1'b1 || bus.mem_wrea !== 1'b0 || bus.mem_ada !== 13'd4095) begin
      n_errors++; $display("FAIL read_port: got rdy %b%b cea %b wrea %b ada %0d want 11 1 0 4095",
                           r0, r1, bus.mem_cea, bus.mem_wrea, bus.mem_ada);
    end
    @(negedge clk); bus.rd_valid = 1'b0;
    n_checks++;
    if (bus.rdata_valid !== 1'b0) begin
      n_errors++; $display("FAIL b2b_early: got rdata_valid %b want 0", bus.rdata_valid);
    end
    @(negedge clk); got[15:8] = bus.rdata_valid ? bus.rdata : 8'hXX;
    n_checks++;
    if (bus.rdata_valid !== 1'b1 || bus.rdata !== 8'hA5) begin
      n_errors++; $display("FAIL b2b_first: got valid %b data %h want 1 a5", bus.rdata_valid, bus.rdata);
    end
    @(negedge clk);
    n_checks++;
    if (bus.rdata_valid !== 1'b1 || bus.rdata !== 8'h3C) begin
      n_errors++; $display("FAIL b2b_second: got valid %b data %h want 1 3c", bus.rdata_valid, bus.rdata);
    end
    @(negedge clk);
    n_checks++;
    if (bus.rdata_valid !== 1'b0) begin
      n_errors++; $display("FAIL b2b_tail: got rdata_valid %b want 0", bus.rdata_valid);
    end
    // Write at edge N then read of the same word at edge N+1.
    @(negedge clk); bus.wr_valid = 1'b1; bus.wr_addr = 13'd200; bus.wr_data = 8'h5A;
    @(negedge clk); bus.wr_valid = 1'b0; bus.rd_valid = 1'b1; bus.rd_addr = 13'd200;
    @(negedge clk); bus.rd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.rdata_valid !== 1'b1 || bus.rdata !== 8'h5A) begin
      n_errors++; $display("FAIL raw_forward: got valid %b data %h want 1 5a", bus.rdata_valid, bus.rdata);
    end
  endtask

  task automatic test_contention();
    logic [DW-1:0] d;
    int            lat;
    logic [7:0]    got;
    logic [7:0]    exp_pat;
`ifdef PIX_ARB_RR_EN
    exp_pat = 8'b10_01_10_01;
`else
    exp_pat = 8'b01_01_01_01;
`endif
    read_word(13'd20, d, lat);
    n_checks++;
    if (lat != 3 || d !== 8'h00) begin
      n_errors++; $display("FAIL lone_read: got %h lat %0d want 00 lat 3", d, lat);
    end
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_addr = 13'd30; bus.wr_data = 8'h10;
    bus.rd_valid = 1'b1; bus.rd_addr = 13'd31;
    for (int i = 0; i < 4; i++) begin
      #1;
      got[2*i +: 2] = {bus.rd_ready, bus.wr_ready};
      @(negedge clk);
      bus.wr_data = bus.wr_data + 8'h01;
    end
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got[2*i +: 2] !== exp_pat[2*i +: 2]) begin
        n_errors++; $display("FAIL contention[%0d]: got rd/wr %b want %b", i, got[2*i +: 2], exp_pat[2*i +: 2]);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_out_of_range();
    logic          acc, cea_seen;
    logic [DW-1:0] d;
    int            lat;
    logic [AW-1:0] oor [2];
    oor[0] = 13'd6144; oor[1] = 13'd8191;
    write_word(13'd5, 8'h77, acc);
    read_word(13'd5, d, lat);
    n_checks++;
    if (lat != 3 || d !== 8'h77) begin
      n_errors++; $display("FAIL prime_read: got %h lat %0d want 77 lat 3", d, lat);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); bus.rd_valid = 1'b1; bus.rd_addr = oor[k]; #1; acc = bus.rd_ready;
      @(negedge clk); bus.rd_valid = 1'b0;
      cea_seen = 1'b0; lat = -1; d = 'x;
      for (int i = 1; i <= 5; i++) begin
        if (bus.mem_cea !== 1'b0) cea_seen = 1'b1;
        if (bus.rdata_valid === 1'b1 && lat < 0) begin lat = i; d = bus.rdata; end
        @(negedge clk);
      end
      n_checks++;
      if (acc !== 1'b1 || cea_seen !== 1'b0 || lat != 3 || d !== 8'h00) begin
        n_errors++; $display("FAIL oor_read[%0d]: got rdy %b cea %b lat %0d data %h want 1 0 3 00",
                             oor[k], acc, cea_seen, lat, d);
      end
    end
    write_word(13'd7000, 8'h11, acc);
    n_checks++;
    if (acc !== 1'b1 || bus.mem_cea !== 1'b0) begin
      n_errors++; $display("FAIL oor_write: got rdy %b cea %b want 1 0", acc, bus.mem_cea);
    end
  endtask

  task automatic test_reset_inflight();
    logic seen = 1'b0;
    @(negedge clk); bus.rd_valid = 1'b1; bus.rd_addr = 13'd4095;
    @(negedge clk); bus.rd_valid = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (5) begin
      if (bus.rdata_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_errors++; $display("FAIL reset_inflight: got rdata_valid seen %b want 0", seen);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic          wr_rdy, found = 1'b0, done_seen = 1'b0, busy_seen = 1'b0;
    logic [DW-1:0] d;
    int            lat;
    @(negedge clk);
    bus.clear_start = 1'b1; bus.wr_valid = 1'b1; bus.wr_addr = 13'd50; bus.wr_data = 8'hEE;
    #1; wr_rdy = bus.wr_ready;
    @(negedge clk); bus.clear_start = 1'b0; bus.wr_valid = 1'b0;
    n_checks++;
    if (wr_rdy !== 1'b0) begin
      n_errors++; $display("FAIL clear_vs_write: got wr_ready %b want 0", wr_rdy);
    end
    for (int i = 0; i < 200 && !found; i++) begin
      if (bus.busy === 1'b1 && bus.mem_ada === 13'd100) found = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!found) begin
      n_errors++; $display("FAIL clear_reach_100: got timeout want address 100 while busy");
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_vec() !== RST_VEC) begin
      n_errors++; $display("FAIL mid_clear_reset: got %h want %h", out_vec(), RST_VEC);
    end
    reset = 1'b0;
    repeat (20) begin
      if (bus.clear_done !== 1'b0) done_seen = 1'b1;
      if (bus.busy !== 1'b0) busy_seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (done_seen !== 1'b0 || busy_seen !== 1'b0) begin
      n_errors++; $display("FAIL aborted_clear: got done %b busy %b want 0 0", done_seen, busy_seen);
    end
    read_word(13'd4095, d, lat);
    n_checks++;
    if (lat != 3 || d !== 8'hA5) begin
      n_errors++; $display("FAIL partial_clear: got %h lat %0d want a5 lat 3", d, lat);
    end
  endtask

  task automatic test_double_clear();
    int busy_cnt = 0, done_cnt = 0, done_idx = -1;
    @(negedge clk); bus.clear_start = 1'b1;
    @(negedge clk); bus.clear_start = 1'b0;
    for (int idx = 1; idx <= int'(DEPTH) + 16; idx++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.clear_done === 1'b1) begin done_cnt++; done_idx = idx; end
      if (idx == 50) bus.clear_start = 1'b1;
      if (idx == 51) bus.clear_start = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (busy_cnt != int'(DEPTH) || done_cnt != 1 || done_idx != int'(DEPTH) + 1) begin
      n_errors++; $display("FAIL double_clear: got busy %0d done %0d at %0d want %0d 1 at %0d",
                           busy_cnt, done_cnt, done_idx, DEPTH, DEPTH + 1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < int'(DEPTH); i++) mem_model[i] = 8'hFF;
    reset           = 1'b1;
    bus.clear_start = 1'b0;
    bus.wr_valid    = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.rd_valid    = 1'b0;
    bus.rd_addr     = '0;
    test_reset();
    test_clear();
    test_back_to_back();
    test_contention();
    test_out_of_range();
    test_reset_inflight();
    test_reset_mid_clear();
    test_double_clear();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
